i2s_tx_serializer: RTL and testbench



---
 rtl/audio_pkg.sv | 18 +
 rtl/aud_frame_fifo.sv | 48 ++++
 rtl/i2s_tx_serializer.sv | 96 +++++++++
 tb/tb_i2s_tx_serializer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared sample-frame type, slot geometry and a ceil-log2 helper for the I2S transmit path.
package audio_pkg;
  localparam int AUD_BIT_DEPTH = 24;
  localparam int SLOT_BITS     = 32;
  localparam int FRAME_BITS    = 64;

  typedef struct packed {
    logic signed [AUD_BIT_DEPTH-1:0] l;
    logic signed [AUD_BIT_DEPTH-1:0] r;
  } aud_frame_t;

  function automatic int clogb2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction
endpackage

// File: rtl/aud_frame_fifo.sv
// Register FIFO of stereo frames; head is visible combinationally, level is registered.
// A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
module aud_frame_fifo
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int F_WIDTH    = clogb2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  aud_frame_t       wdata,
  output aud_frame_t       rdata,
  output logic             full,
  output logic             empty,
  output logic [F_WIDTH:0] level
);
  logic [F_WIDTH:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             do_push, do_pop;
  aud_frame_t       mem [FIFO_DEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[F_WIDTH] != rd_ptr[F_WIDTH]) &&
                   (wr_ptr[F_WIDTH-1:0] == rd_ptr[F_WIDTH-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_nxt  = wr_ptr + (F_WIDTH+1)'(do_push);
  assign rd_nxt  = rd_ptr + (F_WIDTH+1)'(do_pop);
  assign rdata   = mem[rd_ptr[F_WIDTH-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      level  <= wr_nxt - rd_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[F_WIDTH-1:0]] <= wdata;
  end
endmodule

// File: rtl/i2s_tx_serializer.sv
// Buffers mixer frames and serializes them as an I2S master (bclk/lrck/sdata), MSB first.
// Define AUD_LEFT_JUSTIFIED_EN for left-justified slots; default is standard I2S (MSB one bclk after lrck).
module i2s_tx_serializer
  import audio_pkg::*;
#(
  parameter int AUD_BIT_DEPTH = audio_pkg::AUD_BIT_DEPTH,
  parameter int FIFO_DEPTH    = 4,
  parameter int F_WIDTH       = clogb2(FIFO_DEPTH),
  parameter int BCLK_HALF     = 8
) (
  input  logic                     reg_clk,
  input  logic                     reset_n,
  input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
  input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
  input  logic                     sample_valid,
  input  logic                     status_clr,
  output logic                     i2s_bclk,
  output logic                     i2s_lrck,
  output logic                     i2s_sdata,
  output logic [F_WIDTH:0]         fifo_level,
  output logic                     overrun,
  output logic                     underrun
);
  localparam int DIV_W = (clogb2(BCLK_HALF) < 1) ? 1 : clogb2(BCLK_HALF);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt, bit_nxt;
  logic             div_wrap, fall, boundary, pop, fifo_full, fifo_empty;
  logic             set_ovr, set_udr;
  aud_frame_t       hold_frame, head_frame, tx_frame, push_frame;

  assign div_wrap   = (div_cnt == DIV_LAST);
  assign fall       = div_wrap && i2s_bclk;
  assign bit_nxt    = bit_cnt + 6'd1;
  assign boundary   = fall && (bit_nxt == 6'd0);
  assign pop        = boundary && !fifo_empty;
  // The frame popped at a boundary drives that same fall event (its pos 0).
  assign tx_frame   = pop ? head_frame : hold_frame;
  assign push_frame = '{l: lsound_in, r: rsound_in};
  assign set_ovr    = sample_valid && fifo_full && !pop;
  assign set_udr    = boundary && fifo_empty;

  function automatic logic slot_bit(input aud_frame_t f, input logic [5:0] bc);
    logic [AUD_BIT_DEPTH-1:0] s;
    int                       pos;
    s        = bc[5] ? f.r : f.l;
    pos      = int'(bc[4:0]);
    slot_bit = 1'b0;
`ifdef AUD_LEFT_JUSTIFIED_EN
    if (pos < AUD_BIT_DEPTH) slot_bit = s[5'(AUD_BIT_DEPTH - 1 - pos)];
`else
    if (pos >= 1 && pos <= AUD_BIT_DEPTH) slot_bit = s[5'(AUD_BIT_DEPTH - pos)];
`endif
  endfunction

  aud_frame_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .F_WIDTH    (F_WIDTH)
  ) u_fifo (
    .clk   (reg_clk),
    .rst_n (reset_n),
    .push  (sample_valid),
    .pop   (pop),
    .wdata (push_frame),
    .rdata (head_frame),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge reg_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrck   <= 1'b1;
      i2s_sdata  <= 1'b0;
      bit_cnt    <= 6'd63;
      hold_frame <= '0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) i2s_bclk <= !i2s_bclk;
      // lrck/sdata move only on the falling bclk so the codec samples stable data on the rise.
      if (fall) begin
        bit_cnt   <= bit_nxt;
        i2s_lrck  <= bit_nxt[5];
        i2s_sdata <= slot_bit(tx_frame, bit_nxt);
      end
      if (pop) hold_frame <= head_frame;
      overrun  <= set_ovr | (overrun  & ~status_clr);
      underrun <= set_udr | (underrun & ~status_clr);
    end
  end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: bit-exact frame streams, FIFO level and sticky status.
module tb_i2s_tx_serializer;
  logic        reg_clk;
  logic        reset_n;
  logic [23:0] lsound_in, rsound_in;
  logic        sample_valid, status_clr;
  logic        i2s_bclk, i2s_lrck, i2s_sdata;
  logic [2:0]  fifo_level;
  logic        overrun, underrun;

  int vectors = 0;
  int fails   = 0;

  // Expected serial streams, bit k = sdata at bit_cnt k (left slot in [31:0], right in [63:32]).
  localparam logic [63:0] SZ = 64'h0;
`ifdef AUD_LEFT_JUSTIFIED_EN
  localparam logic [63:0] SA  = {32'h007F_FFFE, 32'h0080_0001};
  localparam logic [63:0] SF1 = {32'h0000_0000, 32'h00FF_FFFF};
  localparam logic [63:0] SF2 = {32'h00FF_FFFF, 32'h0000_0000};
  localparam logic [63:0] SF3 = {32'h00C0_0000, 32'h0000_0003};
  localparam logic [63:0] SF4 = {32'h0000_0001, 32'h0080_0000};
  localparam logic [63:0] SF6 = {32'h0080_0000, 32'h0000_0000};
  localparam int          RB  = 55;
`else
  localparam logic [63:0] SA  = {32'h00FF_FFFC, 32'h0100_0002};
  localparam logic [63:0] SF1 = {32'h0000_0000, 32'h01FF_FFFE};
  localparam logic [63:0] SF2 = {32'h01FF_FFFE, 32'h0000_0000};
  localparam logic [63:0] SF3 = {32'h0180_0000, 32'h0000_0006};
  localparam logic [63:0] SF4 = {32'h0000_0002, 32'h0100_0000};
  localparam logic [63:0] SF6 = {32'h0100_0000, 32'h0000_0000};
  localparam int          RB  = 56;
`endif

  i2s_tx_serializer dut (
    .reg_clk      (reg_clk),
    .reset_n      (reset_n),
    .lsound_in    (lsound_in),
    .rsound_in    (rsound_in),
    .sample_valid (sample_valid),
    .status_clr   (status_clr),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .fifo_level   (fifo_level),
    .overrun      (overrun),
    .underrun     (underrun)
  );

  initial reg_clk = 1'b0;
  always #5 reg_clk = ~reg_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advances to just after the next bclk 1->0 transition; cyc = clock edges consumed.
  task automatic next_fall(output int cyc);
    logic prev;
    cyc = -1;
    for (int n = 1; n <= 64; n++) begin
      prev = i2s_bclk;
      @(posedge reg_clk);
      #1;
      if (prev === 1'b1 && i2s_bclk === 1'b0) begin
        cyc = n;
        return;
      end
    end
    vectors++;
    fails++;
    $error("FAIL bclk_fall_timeout: observed no fall in 64 cycles, expected one every 16");
  endtask

  task automatic check_bits(input logic [63:0] stream, input int lo, input int hi,
                            input bit skip_first);
    int cyc;
    for (int k = lo; k <= hi; k++) begin
      next_fall(cyc);
      if (!(skip_first && k == lo)) check($sformatf("bclk_period_b%0d", k), 32'(cyc), 32'd16);
      check($sformatf("lrck_b%0d", k), 32'(i2s_lrck), (k >= 32) ? 32'd1 : 32'd0);
      check($sformatf("sdata_b%0d", k), 32'(i2s_sdata), 32'(stream[6'(k)]));
    end
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    lsound_in    = l;
    rsound_in    = r;
    sample_valid = 1'b1;
    @(posedge reg_clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    status_clr = 1'b1;
    @(posedge reg_clk);
    #1;
    status_clr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sample_valid = 1'b0; status_clr = 1'b0;
    lsound_in = '0; rsound_in = '0;
    repeat (3) @(posedge reg_clk);
    #1;
    check("rst_bclk", 32'(i2s_bclk), 32'd0);
    check("rst_lrck", 32'(i2s_lrck), 32'd1);
    check("rst_sdata", 32'(i2s_sdata), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset_n = 1'b1;

    // Frame 0: nothing buffered, zero hold frame, underrun at the first boundary.
    check_bits(SZ, 0, 0, 1'b0);
    check("f0_underrun", 32'(underrun), 32'd1);
    check("f0_level", 32'(fifo_level), 32'd0);
    check_bits(SZ, 1, 63, 1'b0);

    // Frame 1: single frame pushed into the empty FIFO.
    push(24'h800001, 24'h7FFFFE);
    check("pushA_level", 32'(fifo_level), 32'd1);
    check_bits(SA, 0, 0, 1'b1);
    check("f1_level", 32'(fifo_level), 32'd0);

    // Five back-to-back pushes: fifth is dropped.
    push(24'hFFFFFF, 24'h000000);
    push(24'h000000, 24'hFFFFFF);
    push(24'hC00000, 24'h000003);
    push(24'h000001, 24'h800000);
    push(24'hAAAAAA, 24'h555555);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_overrun", 32'(overrun), 32'd1);
    pulse_clr();
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_underrun", 32'(underrun), 32'd0);
    check_bits(SA, 1, 63, 1'b1);

    // Push on the exact boundary cycle while full: pop frees space, no overrun.
    repeat (15) begin
      @(posedge reg_clk);
      #1;
    end
    lsound_in = 24'h000000; rsound_in = 24'h000001; sample_valid = 1'b1;
    @(posedge reg_clk);
    #1;
    sample_valid = 1'b0;
    check("bnd_bclk", 32'(i2s_bclk), 32'd0);
    check("bnd_lrck", 32'(i2s_lrck), 32'd0);
    check("bnd_sdata", 32'(i2s_sdata), 32'(SF1[0]));
    check("bnd_level", 32'(fifo_level), 32'd4);
    check("bnd_overrun", 32'(overrun), 32'd0);
    check_bits(SF1, 1, 63, 1'b0);
    check_bits(SF2, 0, 63, 1'b0);
    check_bits(SF3, 0, 63, 1'b0);
    check_bits(SF4, 0, 63, 1'b0);

    // Frame 6: last buffered frame, FIFO drains without underrun.
    check_bits(SF6, 0, 0, 1'b0);
    check("f6_level", 32'(fifo_level), 32'd0);
    check("f6_underrun", 32'(underrun), 32'd0);
    check_bits(SF6, 1, 63, 1'b0);

    // Frame 7: empty at boundary, hold frame repeats.
    check_bits(SF6, 0, 0, 1'b0);
    check("f7_underrun", 32'(underrun), 32'd1);
    check("f7_level", 32'(fifo_level), 32'd0);
    pulse_clr();
    check("f7_clr_underrun", 32'(underrun), 32'd0);
    check_bits(SF6, 1, 63, 1'b1);

    // Frame 8: repeat again, then asynchronous reset inside the right slot.
    check_bits(SF6, 0, 50, 1'b0);
    check("f8_underrun", 32'(underrun), 32'd1);
    push(24'hFFFFFF, 24'h000000);
    check("f8_level", 32'(fifo_level), 32'd1);
    check_bits(SF6, 51, RB, 1'b1);
    repeat (10) begin
      @(posedge reg_clk);
      #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_bclk", 32'(i2s_bclk), 32'd0);
    check("arst_lrck", 32'(i2s_lrck), 32'd1);
    check("arst_sdata", 32'(i2s_sdata), 32'd0);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_underrun", 32'(underrun), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    @(posedge reg_clk);
    #1;
    reset_n = 1'b1;

    // After release: FIFO empty, hold frame cleared.
    check_bits(SZ, 0, 0, 1'b0);
    check("rel_level", 32'(fifo_level), 32'd0);
    check("rel_underrun", 32'(underrun), 32'd1);
    check_bits(SZ, 1, 63, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
